// File: rtl/fir_tdm_scheduler.sv
// Time-division scheduler: serialises stereo pairs into a framed two-beat FIR sink
// stream with a one-deep pending slot, and reassembles filtered beats into stereo words.
module fir_tdm_scheduler #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 24
) (
   input  logic             AMCLK_i,
   input  logic             ARST_i,
   input  logic [IN_W-1:0]  APDATA_LEFT_i,
   input  logic [IN_W-1:0]  APDATA_RIGHT_i,
   input  logic             APDATA_VALID_i,
   output logic [IN_W-1:0]  sink_data_o,
   output logic             sink_valid_o,
   output logic             sink_sop_o,
   output logic             sink_eop_o,
   input  logic [OUT_W-1:0] source_data_i,
   input  logic             source_valid_i,
   input  logic             source_sop_i,
   input  logic             source_eop_i,
   output logic [OUT_W-1:0] APDATA_INT_LEFT_o,
   output logic [OUT_W-1:0] APDATA_INT_RIGHT_o,
   output logic             APDATA_INT_VALID_o,
   input  logic             clr_status_i,
   output logic             overrun_o,
   output logic             proto_err_o
);

   typedef enum logic [1:0] {S_IDLE, S_SEND_L, S_SEND_R, S_GAP} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              w_launch;
   logic              r_pend_full;
   logic [IN_W-1:0]   r_pend_l, r_pend_r;
   logic [IN_W-1:0]   r_frame_l, r_frame_r;
   logic              r_got_l;
   logic [OUT_W-1:0]  r_shadow_l;
   logic              w_ovr_set, w_err_set;

   assign w_launch = ((r_state == S_IDLE) || (r_state == S_GAP)) &&
                     (APDATA_VALID_i || r_pend_full);

   always_ff @(posedge AMCLK_i or posedge ARST_i) begin
      if (ARST_i) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = w_launch ? S_SEND_L : S_IDLE;
         S_SEND_L: w_next = S_SEND_R;
         S_SEND_R: w_next = S_GAP;
         S_GAP:    w_next = w_launch ? S_SEND_L : S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Sink outputs decode the state register and frame register only.
   always_comb begin
      sink_data_o  = '0;
      sink_valid_o = 1'b0;
      sink_sop_o   = 1'b0;
      sink_eop_o   = 1'b0;
      case (r_state)
         S_SEND_L: begin
            sink_data_o  = r_frame_l;
            sink_valid_o = 1'b1;
            sink_sop_o   = 1'b1;
         end
         S_SEND_R: begin
            sink_data_o  = r_frame_r;
            sink_valid_o = 1'b1;
            sink_eop_o   = 1'b1;
         end
         default: ;
      endcase
   end

   // Pending pair launches first; a simultaneous live pair refills the freed slot.
   assign w_ovr_set = APDATA_VALID_i && r_pend_full && !w_launch;

   always_ff @(posedge AMCLK_i or posedge ARST_i) begin
      if (ARST_i) begin
         r_pend_full <= 1'b0;
         r_pend_l    <= '0;
         r_pend_r    <= '0;
         r_frame_l   <= '0;
         r_frame_r   <= '0;
      end else if (w_launch) begin
         if (r_pend_full) begin
            r_frame_l   <= r_pend_l;
            r_frame_r   <= r_pend_r;
            r_pend_full <= APDATA_VALID_i;
            if (APDATA_VALID_i) begin
               r_pend_l <= APDATA_LEFT_i;
               r_pend_r <= APDATA_RIGHT_i;
            end
         end else begin
            r_frame_l <= APDATA_LEFT_i;
            r_frame_r <= APDATA_RIGHT_i;
         end
      end else if (APDATA_VALID_i) begin
         r_pend_full <= 1'b1;
         r_pend_l    <= APDATA_LEFT_i;
         r_pend_r    <= APDATA_RIGHT_i;
      end
   end

   assign w_err_set = source_valid_i &&
                      ((source_sop_i == source_eop_i) ||
                       (source_sop_i && r_got_l) ||
                       (source_eop_i && !r_got_l));

   always_ff @(posedge AMCLK_i or posedge ARST_i) begin
      if (ARST_i) begin
         r_got_l            <= 1'b0;
         r_shadow_l         <= '0;
         APDATA_INT_LEFT_o  <= '0;
         APDATA_INT_RIGHT_o <= '0;
         APDATA_INT_VALID_o <= 1'b0;
      end else begin
         APDATA_INT_VALID_o <= 1'b0;
         if (source_valid_i && source_sop_i && !source_eop_i) begin
            r_shadow_l <= source_data_i;
            r_got_l    <= 1'b1;
         end else if (source_valid_i && source_eop_i && !source_sop_i && r_got_l) begin
            APDATA_INT_LEFT_o  <= r_shadow_l;
            APDATA_INT_RIGHT_o <= source_data_i;
            APDATA_INT_VALID_o <= 1'b1;
            r_got_l            <= 1'b0;
         end
      end
   end

   // Set wins over a coincident clear.
   always_ff @(posedge AMCLK_i or posedge ARST_i) begin
      if (ARST_i) begin
         overrun_o   <= 1'b0;
         proto_err_o <= 1'b0;
      end else begin
         if (w_ovr_set)         overrun_o <= 1'b1;
         else if (clr_status_i) overrun_o <= 1'b0;
         if (w_err_set)         proto_err_o <= 1'b1;
         else if (clr_status_i) proto_err_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_tdm_scheduler.sv
// Directed bench for fir_tdm_scheduler: sink framing, pending/overrun, source reassembly,
// framing errors, asynchronous reset mid-frame and a 1000-pair echo soak.
module tb_fir_tdm_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_l, in_r;
   logic        in_valid;
   logic [15:0] sink_data;
   logic        sink_valid, sink_sop, sink_eop;
   logic [23:0] src_data;
   logic        src_valid, src_sop, src_eop;
   logic [23:0] out_l, out_r;
   logic        out_valid;
   logic        clr;
   logic        overrun, proto_err;

   int          n_checks = 0;
   int          n_errors = 0;

   fir_tdm_scheduler #(.IN_W(16), .OUT_W(24)) dut (
      .AMCLK_i            (clk),
      .ARST_i             (rst),
      .APDATA_LEFT_i      (in_l),
      .APDATA_RIGHT_i     (in_r),
      .APDATA_VALID_i     (in_valid),
      .sink_data_o        (sink_data),
      .sink_valid_o       (sink_valid),
      .sink_sop_o         (sink_sop),
      .sink_eop_o         (sink_eop),
      .source_data_i      (src_data),
      .source_valid_i     (src_valid),
      .source_sop_i       (src_sop),
      .source_eop_i       (src_eop),
      .APDATA_INT_LEFT_o  (out_l),
      .APDATA_INT_RIGHT_o (out_r),
      .APDATA_INT_VALID_o (out_valid),
      .clr_status_i       (clr),
      .overrun_o          (overrun),
      .proto_err_o        (proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_beat(input string tag, input logic v, input logic s, input logic e,
                           input logic [15:0] d);
      chk({tag, "_valid"}, 32'(sink_valid), 32'(v));
      chk({tag, "_sop"},   32'(sink_sop),   32'(s));
      chk({tag, "_eop"},   32'(sink_eop),   32'(e));
      if (v) chk({tag, "_data"}, 32'(sink_data), 32'(d));
   endtask

   task automatic pair(input logic [15:0] l, input logic [15:0] r);
      in_l = l; in_r = r; in_valid = 1'b1;
   endtask

   task automatic beat(input logic v, input logic s, input logic e, input logic [23:0] d);
      src_valid = v; src_sop = s; src_eop = e; src_data = d;
   endtask

   task automatic clear_flags();
      clr = 1'b1; tick(); clr = 1'b0;
   endtask

   initial begin
      logic [15:0] el, er, sl, sr;
      logic [15:0] q_l[$];
      logic [15:0] q_r[$];
      int sent, got;

      rst = 1'b1; in_l = '0; in_r = '0; in_valid = 1'b0; clr = 1'b0;
      beat(1'b0, 1'b0, 1'b0, 24'h0);
      #1;
      chk("rst_sink_valid", 32'(sink_valid), 32'd0);
      chk("rst_sink_data",  32'(sink_data),  32'd0);
      chk("rst_out_valid",  32'(out_valid),  32'd0);
      chk("rst_out_l",      32'(out_l),      32'd0);
      chk("rst_out_r",      32'(out_r),      32'd0);
      chk("rst_overrun",    32'(overrun),    32'd0);
      chk("rst_proto",      32'(proto_err),  32'd0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // single pair; inputs change right after the strobe
      pair(16'h1234, 16'hABCD);
      tick();
      in_valid = 1'b0; in_l = 16'h5555; in_r = 16'h6666;
      chk_beat("single_l", 1'b1, 1'b1, 1'b0, 16'h1234);
      tick(); chk_beat("single_r", 1'b1, 1'b0, 1'b1, 16'hABCD);
      tick(); chk_beat("single_gap", 1'b0, 1'b0, 1'b0, 16'h0);
      tick(); chk_beat("single_idle", 1'b0, 1'b0, 1'b0, 16'h0);
      chk("single_overrun", 32'(overrun), 32'd0);

      // back-to-back A,B,C: B overwritten by C
      pair(16'hAAA1, 16'hAAA2);
      tick(); chk_beat("b2b_A_l", 1'b1, 1'b1, 1'b0, 16'hAAA1);
      pair(16'hBBB1, 16'hBBB2);
      tick(); chk_beat("b2b_A_r", 1'b1, 1'b0, 1'b1, 16'hAAA2);
      pair(16'hCCC1, 16'hCCC2);
      tick(); in_valid = 1'b0;
      chk_beat("b2b_gap", 1'b0, 1'b0, 1'b0, 16'h0);
      chk("b2b_overrun", 32'(overrun), 32'd1);
      tick(); chk_beat("b2b_C_l", 1'b1, 1'b1, 1'b0, 16'hCCC1);
      tick(); chk_beat("b2b_C_r", 1'b1, 1'b0, 1'b1, 16'hCCC2);
      tick(); chk_beat("b2b_gap2", 1'b0, 1'b0, 1'b0, 16'h0);
      tick(); chk_beat("b2b_idle", 1'b0, 1'b0, 1'b0, 16'h0);
      clear_flags();
      chk("b2b_ovr_clr", 32'(overrun), 32'd0);

      // source reassembly
      beat(1'b1, 1'b1, 1'b0, 24'h0F0000);
      tick(); beat(1'b1, 1'b0, 1'b1, 24'h00F000);
      chk("reasm_early_valid", 32'(out_valid), 32'd0);
      tick(); beat(1'b0, 1'b0, 1'b0, 24'h0);
      chk("reasm_valid", 32'(out_valid), 32'd1);
      chk("reasm_left",  32'(out_l), 32'h0F0000);
      chk("reasm_right", 32'(out_r), 32'h00F000);
      chk("reasm_proto", 32'(proto_err), 32'd0);
      tick();
      chk("reasm_valid_1cyc", 32'(out_valid), 32'd0);
      chk("reasm_left_hold",  32'(out_l), 32'h0F0000);

      // eop with no left beat
      beat(1'b1, 1'b0, 1'b1, 24'h123456);
      tick(); beat(1'b0, 1'b0, 1'b0, 24'h0);
      chk("eop_only_proto", 32'(proto_err), 32'd1);
      chk("eop_only_valid", 32'(out_valid), 32'd0);
      chk("eop_only_right", 32'(out_r), 32'h00F000);
      clear_flags();
      chk("proto_clr", 32'(proto_err), 32'd0);
      clr = 1'b1; beat(1'b1, 1'b0, 1'b1, 24'h654321);
      tick(); clr = 1'b0; beat(1'b0, 1'b0, 1'b0, 24'h0);
      chk("proto_set_wins", 32'(proto_err), 32'd1);
      clear_flags();

      // sop=eop beat is ignored
      beat(1'b1, 1'b1, 1'b1, 24'h777777);
      tick(); beat(1'b0, 1'b0, 1'b0, 24'h0);
      chk("both_proto", 32'(proto_err), 32'd1);
      chk("both_valid", 32'(out_valid), 32'd0);
      clear_flags();

      // repeated sop: newer left wins
      beat(1'b1, 1'b1, 1'b0, 24'h111111);
      tick(); beat(1'b1, 1'b1, 1'b0, 24'h222222);
      tick(); beat(1'b1, 1'b0, 1'b1, 24'h333333);
      chk("dup_sop_proto", 32'(proto_err), 32'd1);
      tick(); beat(1'b0, 1'b0, 1'b0, 24'h0);
      chk("dup_sop_valid", 32'(out_valid), 32'd1);
      chk("dup_sop_left",  32'(out_l), 32'h222222);
      chk("dup_sop_right", 32'(out_r), 32'h333333);
      clear_flags();

      // reset during SEND_L with a pair pending and a left shadow held
      beat(1'b1, 1'b1, 1'b0, 24'h0ABCDE);
      pair(16'h0101, 16'h0202);
      tick(); beat(1'b0, 1'b0, 1'b0, 24'h0);
      pair(16'h0303, 16'h0404);
      tick(); in_valid = 1'b0;
      tick();
      pair(16'h0505, 16'h0606);
      tick(); in_valid = 1'b0;
      chk_beat("rmf_sendl", 1'b1, 1'b1, 1'b0, 16'h0303);
      #2 rst = 1'b1;
      #1 chk("rmf_async_valid", 32'(sink_valid), 32'd0);
      tick(); rst = 1'b0;
      sl = '0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (sink_valid || sink_eop) sl = sl + 16'd1;
      end
      chk("rmf_no_beats", 32'(sl), 32'd0);
      chk("rmf_overrun", 32'(overrun), 32'd0);
      beat(1'b1, 1'b0, 1'b1, 24'h0F0F0F);
      tick(); beat(1'b0, 1'b0, 1'b0, 24'h0);
      chk("rmf_shadow_gone_proto", 32'(proto_err), 32'd1);
      chk("rmf_shadow_gone_valid", 32'(out_valid), 32'd0);
      clear_flags();

      // soak: one pair every 3 cycles, FIR modelled as an echo appending 8'hC3
      sent = 0; got = 0;
      for (int c = 0; c < 3300 && got < 1000; c++) begin
         if (out_valid) begin
            if (q_l.size() > 0) begin
               el = q_l.pop_front(); er = q_r.pop_front();
               chk("soak_left",  32'(out_l), 32'({el, 8'hC3}));
               chk("soak_right", 32'(out_r), 32'({er, 8'hC3}));
            end else begin
               chk("soak_extra_pulse", 32'd1, 32'd0);
            end
            got++;
         end
         if ((c % 3) == 0 && sent < 1000) begin
            sl = 16'(sent * 7 + 3);
            sr = ~sl;
            pair(sl, sr);
            q_l.push_back(sl); q_r.push_back(sr);
            sent++;
         end else begin
            in_valid = 1'b0;
         end
         beat(sink_valid, sink_sop, sink_eop, {sink_data, 8'hC3});
         tick();
      end
      in_valid = 1'b0;
      beat(1'b0, 1'b0, 1'b0, 24'h0);
      chk("soak_pulses",  32'(got), 32'd1000);
      chk("soak_overrun", 32'(overrun), 32'd0);
      chk("soak_proto",   32'(proto_err), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
